// File: rtl/onchip_mem_bist_master.sv
// Memory self-test master for the single-port on-chip RAM (Avalon-MM s1 port).
// A start pulse runs two passes over a word window:
//   1. write a 32-bit Galois LFSR sequence;
//   2. read the window back and compare each word against the regenerated sequence.
// The test reports pass/fail, a saturating mismatch count and the first failing address.
module onchip_mem_bist_master #(
  parameter int          ADDR_W = 14,
  parameter int          DATA_W = 32,
  parameter int          DEPTH  = 10240,
  parameter logic [31:0] POLY   = 32'h04C11DB7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t              state;
  logic [31:0]         lfsr;
  logic [31:0]         seed_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   count_q;
  logic [ADDR_W-1:0]   cnt;
  logic                err_seen;

  // Compare pipeline: p0 travels with the read on the bus, p1 lines up with readdata.
  logic                vld_p0;
  logic [DATA_W-1:0]   exp_p0;
  logic                vld_p1;
  logic [DATA_W-1:0]   exp_p1;
  logic [ADDR_W-1:0]   addr_p1;

  logic [15:0]         err_next;
  logic [ADDR_W-1:0]   first_next;
  logic                seen_next;
  logic [31:0]         seed_eff;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? POLY : 32'h0);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_eff = (seed == 32'h0) ? 32'h1 : seed;

  // Result of comparing the returning read word against the delayed expected value.
  always_comb begin
    err_next   = err_count;
    first_next = first_err_addr;
    seen_next  = err_seen;
    if (vld_p1 && (readdata != exp_p1)) begin
      err_next = sat_inc(err_count);
      if (!err_seen) begin
        first_next = addr_p1;
        seen_next  = 1'b1;
      end
    end
  end

  // Test sequencer with registered bus and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      lfsr           <= '0;
      seed_q         <= '0;
      base_q         <= '0;
      count_q        <= '0;
      cnt            <= '0;
      err_seen       <= 1'b0;
      vld_p0         <= 1'b0;
      exp_p0         <= '0;
      vld_p1         <= 1'b0;
      exp_p1         <= '0;
      addr_p1        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      address        <= '0;
      byteenable     <= '0;
      chipselect     <= 1'b0;
      write          <= 1'b0;
      writedata      <= '0;
    end else begin
      // stage p0 -> p1: the read issued last cycle now has its data on readdata
      vld_p1  <= vld_p0;
      exp_p1  <= exp_p0;
      addr_p1 <= address;

      case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            err_count      <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
            if (word_count != '0) begin
              state      <= WRITE;
              busy       <= 1'b1;
              done       <= 1'b0;
              pass       <= 1'b0;
              base_q     <= base_addr;
              count_q    <= word_count;
              seed_q     <= seed_eff;
              chipselect <= 1'b1;
              write      <= 1'b1;
              byteenable <= 4'hF;
              address    <= base_addr;
              writedata  <= seed_eff;
              lfsr       <= lfsr_step(seed_eff);
              cnt        <= ADDR_W'(1);
            end else begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (cnt == count_q) begin
            // Last write is on the bus; rewind address and pattern for the read pass.
            state   <= READ;
            write   <= 1'b0;
            address <= base_q;
            exp_p0  <= seed_q;
            vld_p0  <= 1'b1;
            lfsr    <= lfsr_step(seed_q);
            cnt     <= ADDR_W'(1);
          end else begin
            address   <= addr_inc(address);
            writedata <= lfsr;
            lfsr      <= lfsr_step(lfsr);
            cnt       <= cnt + 1'b1;
          end
        end

        READ: begin
          err_count      <= err_next;
          first_err_addr <= first_next;
          err_seen       <= seen_next;
          if (cnt == count_q) begin
            state      <= DRAIN;
            chipselect <= 1'b0;
            byteenable <= 4'h0;
            vld_p0     <= 1'b0;
          end else begin
            address <= addr_inc(address);
            exp_p0  <= lfsr;
            lfsr    <= lfsr_step(lfsr);
            cnt     <= cnt + 1'b1;
          end
        end

        DRAIN: begin
          // The final read's data is compared here; pass must include it.
          err_count      <= err_next;
          first_err_addr <= first_next;
          err_seen       <= seen_next;
          state          <= DONE;
          busy           <= 1'b0;
          done           <= 1'b1;
          pass           <= (err_next == 16'h0);
        end

        default: state <= IDLE;
      endcase

      // Abort overrides everything above and discards any compare still in flight.
      if (abort && (state == WRITE || state == READ || state == DRAIN)) begin
        state          <= IDLE;
        busy           <= 1'b0;
        done           <= 1'b0;
        pass           <= 1'b0;
        chipselect     <= 1'b0;
        write          <= 1'b0;
        byteenable     <= 4'h0;
        vld_p0         <= 1'b0;
        vld_p1         <= 1'b0;
        err_count      <= err_count;
        first_err_addr <= first_err_addr;
        err_seen       <= err_seen;
      end
    end
  end

endmodule

// File: tb/tb_onchip_mem_bist_master.sv
// Bench for onchip_mem_bist_master: behavioural RAM with read-bit fault injection,
// a bus scoreboard of expected accesses, and a table of whole-test vectors.
module tb_onchip_mem_bist_master;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 10240;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] word_count = '0;
  logic [31:0]       seed = '0;
  logic              busy, done, pass;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr, address;
  logic [3:0]        byteenable;
  logic              chipselect, write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata = '0;

  onchip_mem_bist_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .write(write), .writedata(writedata), .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          base;
    int          count;
    logic [31:0] seed;
    int          flip_a;
    int          flip_b;
    logic        exp_pass;
    int          exp_err;
    int          exp_first;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       data;
  } acc_t;

  acc_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          flip_a = -1;
  int          flip_b = -1;
  logic        mon_en = 1'b0;
  logic [31:0] mem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    logic [31:0] n;
    n = {l[30:0], 1'b0};
    if (l[31]) n = n ^ 32'h04C11DB7;
    return n;
  endfunction

  // RAM model: 1-cycle read latency, optional bit-0 flip on two read addresses.
  always @(posedge clk) begin
    if (chipselect && write) mem[address] <= writedata;
    if (chipselect && !write)
      readdata <= mem[address] ^ (((int'(address) == flip_a) || (int'(address) == flip_b)) ? 32'h1 : 32'h0);
  end

  // Bus monitor: every access must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      acc_t e;
      check("byteenable", {28'h0, byteenable}, chipselect ? 32'hF : 32'h0);
      check("write_without_cs", {31'h0, write & ~chipselect}, 32'h0);
      if (chipselect) begin
        if (sb.size() == 0) begin
          check("unexpected_access", {18'h0, address}, 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          check("acc_addr", {18'h0, address}, {18'h0, e.addr});
          check("acc_we", {31'h0, write}, {31'h0, e.we});
          if (e.we) check("acc_wdata", writedata, e.data);
        end
      end
    end
  end

  task automatic push_run(input int base, input int count, input logic [31:0] sd,
                          input int nwr, input int nrd);
    logic [31:0] l;
    int a;
    acc_t e;
    l = (sd == 32'h0) ? 32'h1 : sd;
    a = base;
    for (int i = 0; i < nwr; i++) begin
      e.addr = a[ADDR_W-1:0]; e.we = 1'b1; e.data = l;
      sb.push_back(e);
      l = lfsr_next(l);
      a = (a == DEPTH - 1) ? 0 : a + 1;
    end
    a = base;
    for (int i = 0; i < nrd; i++) begin
      e.addr = a[ADDR_W-1:0]; e.we = 1'b0; e.data = 32'h0;
      sb.push_back(e);
      a = (a == DEPTH - 1) ? 0 : a + 1;
    end
    if (count < 0) $display("bad count");
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int n;
    n = v.count;
    lat = -1;
    @(negedge clk);
    flip_a = v.flip_a;
    flip_b = v.flip_b;
    base_addr = v.base[ADDR_W-1:0];
    word_count = v.count[ADDR_W-1:0];
    seed = v.seed;
    start = 1'b1;
    push_run(v.base, v.count, v.seed, n, n);
    for (int c = 1; c <= 2 * n + 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, "_done_cycle"}, lat, (n == 0) ? 1 : 2 * n + 2);
    check({tag, "_pass"}, {31'h0, pass}, {31'h0, v.exp_pass});
    check({tag, "_err_count"}, {16'h0, err_count}, v.exp_err);
    check({tag, "_first_err_addr"}, {18'h0, first_err_addr}, v.exp_first);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_sb_empty"}, sb.size(), 0);
    sb.delete();
    flip_a = -1;
    flip_b = -1;
  endtask

  vec_t vecs[7];
  vec_t clean;

  initial begin
    vecs[0] = '{0,     4, 32'h1,        -1,    -1, 1'b1, 0, 0};
    vecs[1] = '{0,     4, 32'h1,         2,    -1, 1'b0, 1, 2};
    vecs[2] = '{10238, 4, 32'hDEADBEEF, -1,    -1, 1'b1, 0, 0};
    vecs[3] = '{0,     0, 32'h1,        -1,    -1, 1'b1, 0, 0};
    vecs[4] = '{100,   5, 32'h0,        -1,    -1, 1'b1, 0, 0};
    vecs[5] = '{50,    6, 32'h80000000, 52,    55, 1'b0, 2, 52};
    vecs[6] = '{10238, 4, 32'h13579BDF, 10239, 0,  1'b0, 2, 10239};
    clean   = '{400,   8, 32'hCAFEF00D, -1,    -1, 1'b1, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_pass", {31'h0, pass}, 32'h0);
    check("rst_err_count", {16'h0, err_count}, 32'h0);
    check("rst_first_err", {18'h0, first_err_addr}, 32'h0);
    check("rst_chipselect", {31'h0, chipselect}, 32'h0);
    check("rst_address", {18'h0, address}, 32'h0);
    check("rst_writedata", writedata, 32'h0);
    reset_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort on the second write cycle of an 8-word run
    @(negedge clk);
    base_addr = 14'd200; word_count = 14'd8; seed = 32'h7; start = 1'b1;
    push_run(200, 8, 32'h7, 2, 0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_chipselect", {31'h0, chipselect}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_sb_empty", sb.size(), 0);
    sb.delete();
    // Abort and start together: abort wins, nothing starts
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("abort_start_busy", {31'h0, busy}, 32'h0);
    check("abort_start_cs", {31'h0, chipselect}, 32'h0);
    run_vec(clean, "after_abort");

    // Reset asserted during the read pass
    @(negedge clk);
    base_addr = 14'd300; word_count = 14'd8; seed = 32'h1234; start = 1'b1;
    push_run(300, 8, 32'h1234, 8, 3);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    #1 reset_n = 1'b0;
    #1;
    check("midrst_chipselect", {31'h0, chipselect}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_err_count", {16'h0, err_count}, 32'h0);
    repeat (3) @(negedge clk);
    check("midrst_sb_empty", sb.size(), 0);
    sb.delete();
    reset_n = 1'b1;
    run_vec(clean, "after_reset");

    @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/onchip_mem_bist_master.md
Name: onchip_mem_bist_master

Overview:
- Avalon-MM master that drives the s1 port of the 10240x32 single-port on-chip RAM directly, point-to-point, with no interconnect in between.
- On a start pulse it writes a pseudo-random LFSR pattern over a word-address window, reads the window back and compares each word.
- Reports pass/fail, a saturating error count and the first failing address.
- Used for power-on memory self-test and for soak testing of the on-chip RAM.

Parameters:
- ADDR_W, 14, word-address width; matches the RAM address port.
- DATA_W, 32, data width; the LFSR is fixed at 32 bits, so DATA_W must equal 32.
- DEPTH, 10240, number of RAM words; addresses wrap from DEPTH-1 to 0.
- POLY, 32'h04C11DB7, Galois LFSR feedback polynomial.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE.
- abort  in  1  ends the current test; the block goes to IDLE.
- base_addr  in  ADDR_W  first word address of the window; must be below DEPTH.
- word_count  in  ADDR_W  number of words to test, 0..DEPTH.
- seed  in  32  initial LFSR value; a value of 0 is replaced by 32'h1.
- busy  out  1  high in WRITE, READ and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid while done=1; high when err_count=0.
- err_count  out  16  mismatch count; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if there was none.
- address  out  ADDR_W  RAM word address.
- byteenable  out  4  4'hF while chipselect=1, otherwise 4'h0.
- chipselect  out  1  RAM select.
- write  out  1  write strobe; only ever high together with chipselect.
- writedata  out  DATA_W  write data.
- readdata  in  DATA_W  RAM read data; fixed read latency of 1 cycle, no waitrequest.

Behaviour:
- Reset (reset_n low) clears all outputs, counters and state to 0 and puts the FSM in IDLE; reset takes effect immediately, including mid-test.
- LFSR step: next = {l[30:0],1'b0} ^ (l[31] ? POLY : 0).
- Pattern: word k of the window carries LFSR state k, where state 0 = seed.
- Address sequence: the address starts at base_addr and increments by 1 per issued access; DEPTH-1 is followed by 0.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE/DONE -> WRITE on start when word_count != 0. On entry, clear err_count, first_err_addr and the error-seen flag, and load the LFSR with seed.
- IDLE/DONE -> DONE on start when word_count = 0; result is pass=1, err_count=0.
- WRITE, one word per cycle:
  - chipselect=1, write=1, writedata = LFSR, then the LFSR steps and the address increments.
  - After word_count writes: go to READ, reload the LFSR with seed and the address with base_addr.
- READ, one read per cycle:
  - chipselect=1, write=0.
  - Expected value = LFSR, registered alongside the address into a 1-deep compare pipeline.
  - After word_count reads: go to DRAIN.
- Compare: the cycle after each read, readdata is compared with the registered expected value.
  - On mismatch: err_count increments (saturating).
  - On the first mismatch only: first_err_addr is loaded with the registered address.
- DRAIN: one cycle, chipselect=0; completes the last compare, then goes to DONE.
- DONE: done=1 and pass=(err_count==0); results hold until the next start.
- Timing for start sampled at edge 0 with N words:
  - writes occupy cycles 1..N;
  - reads occupy cycles N+1..2N;
  - DRAIN is cycle 2N+1;
  - done=1 from cycle 2N+2.
- abort in WRITE, READ or DRAIN:
  - Next cycle: IDLE, chipselect=0, busy=0, done=0.
  - A compare pending in the pipeline is discarded.
  - err_count and first_err_addr keep their current values.
- abort and start in the same cycle: abort wins.
- start while busy: ignored.
- Between accesses (IDLE, DRAIN, DONE): chipselect=0, write=0, address held at its last value.

Test Plan:
- Reset release, then start with base=0, count=4, seed=1, clean RAM model -> writes 1,2,4,8 to addresses 0..3; reads of 0..3 follow back-to-back; done at cycle 10; pass=1; err_count=0.
- Same run with the model flipping bit 0 of the word read at address 2 -> err_count=1, first_err_addr=2, pass=0.
- base=10238, count=4 -> accesses at 10238, 10239, 0, 1; pass=1.
- count=0 -> no chipselect at any time; done one cycle after start; pass=1.
- abort on the 2nd write cycle of a count=8 run -> IDLE next cycle, chipselect=0, done=0; a following start runs a full clean test to pass=1.
- reset_n low during READ -> chipselect, busy, done and err_count are 0 immediately; no further bus activity; after release a start completes with pass=1.
